// File: rtl/diff_scan.sv
// diff_scan: compares two operands a fixed number of chunks at a time.
// It captures X = A ^ B and then scans X one CHUNK-bit slice per cycle,
// lowest slice first. Depending on mode, the result is the lowest differing
// bit index, the highest differing bit index, the Hamming distance, or the
// XOR parity. Latency is always NCH cycles, whatever the data.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  / in_ready   request handshake (in_ready only in IDLE)
//   A, B      operands (sampled only on the accepting edge)
//   mode      0=lowest diff bit, 1=highest diff bit, 2=popcount, 3=parity
//   out_valid / out_ready  result handshake (out_valid only in HOLD)
//   result    index / count / parity; WIDTH means "no difference" in modes 0/1
//   eq        captured A == B
module diff_scan #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int RW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    result,
  output logic             eq
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [1:0]       r_mode;
  logic [KW-1:0]    r_k;
  logic             r_any;    // some set bit already seen in earlier chunks
  logic [RW-1:0]    r_idx;
  logic [RW-1:0]    r_cnt;
  logic             r_par;
  logic [RW-1:0]    r_result;
  logic             r_eq;

  logic [CHUNK-1:0] w_chunk;
  logic [RW-1:0]    w_base;
  logic [RW-1:0]    w_lo;
  logic [RW-1:0]    w_hi;
  logic [RW-1:0]    w_pop;
  logic             w_hit;
  logic             w_any_nxt;
  logic [RW-1:0]    w_idx_nxt;
  logic [RW-1:0]    w_cnt_nxt;
  logic             w_par_nxt;
  logic [RW-1:0]    w_res_fin;
  logic             w_last;

  assign w_chunk = CHUNK'(r_x >> (int'(r_k) * CHUNK));
  assign w_base  = RW'(int'(r_k) * CHUNK);
  assign w_hit   = |w_chunk;
  assign w_last  = (r_k == KW'(NCH - 1));

  // Lowest / highest set bit and popcount within the current slice.
  always_comb begin
    w_lo  = '0;
    w_hi  = '0;
    w_pop = '0;
    for (int i = CHUNK - 1; i >= 0; i--)
      if (w_chunk[i]) w_lo = RW'(i);
    for (int i = 0; i < CHUNK; i++) begin
      if (w_chunk[i]) w_hi = RW'(i);
      w_pop = w_pop + RW'(w_chunk[i]);
    end
  end

  // Accumulator updates for this slice. Mode 0 keeps the first index found;
  // mode 1 lets every later hit overwrite, leaving the highest.
  always_comb begin
    w_any_nxt = r_any | w_hit;
    w_idx_nxt = r_idx;
    if (w_hit) begin
      if (r_mode == 2'd1)  w_idx_nxt = w_base + w_hi;
      else if (!r_any)     w_idx_nxt = w_base + w_lo;
    end
    w_cnt_nxt = r_cnt + w_pop;
    w_par_nxt = r_par ^ (^w_chunk);
    case (r_mode)
      2'd0, 2'd1: w_res_fin = w_any_nxt ? w_idx_nxt : RW'(WIDTH);
      2'd2:       w_res_fin = w_cnt_nxt;
      default:    w_res_fin = RW'(w_par_nxt);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_mode   <= '0;
      r_k      <= '0;
      r_any    <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_result <= '0;
      r_eq     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x     <= A ^ B;
          r_mode  <= mode;
          r_k     <= '0;
          r_any   <= 1'b0;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_par   <= 1'b0;
          r_state <= SCAN;
        end
        SCAN: begin
          r_any <= w_any_nxt;
          r_idx <= w_idx_nxt;
          r_cnt <= w_cnt_nxt;
          r_par <= w_par_nxt;
          r_k   <= r_k + KW'(1);
          if (w_last) begin
            r_result <= w_res_fin;
            r_eq     <= ~w_any_nxt;
            r_k      <= '0;
            r_state  <= HOLD;
          end
        end
        HOLD: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign result    = r_result;
  assign eq        = r_eq;

endmodule

// File: tb/tb_diff_scan.sv
// Bench for diff_scan (WIDTH=32, CHUNK=8): a vector table plus a few
// random requests checked against a whole-word reference function, and
// hand-written sequences for backpressure, back-to-back handoff and reset.
module tb_diff_scan;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int RW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [1:0]       mode = '0;
  logic             in_ready;
  logic             out_valid;
  logic [RW-1:0]    result;
  logic             eq;

  diff_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .eq(eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       m;
    logic [RW-1:0]    r;
    logic             e;
  } vec_t;

  typedef struct packed {
    logic [RW-1:0] r;
    logic          e;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole-word reference: no chunking, just the definition of each mode.
  function automatic exp_t ref_calc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic [1:0] m);
    logic [WIDTH-1:0] x;
    exp_t o;
    x = a ^ b;
    o.e = (x == '0);
    o.r = '0;
    case (m)
      2'd0: begin
        o.r = RW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) if (x[i]) o.r = RW'(i);
      end
      2'd1: begin
        o.r = RW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (x[i]) o.r = RW'(i);
      end
      2'd2: o.r = RW'($countones(x));
      default: o.r = RW'(^x);
    endcase
    return o;
  endfunction

  // Called at a negedge. Waits for in_ready, presents the request for one
  // edge, then scrambles the inputs so the in-flight result must not care.
  task automatic drive_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [1:0] m, input logic [RW-1:0] r, input logic e);
    int n = 0;
    exp_t x;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before_req", 32'(in_ready), 32'd1);
    A = a; B = b; mode = m; in_valid = 1'b1;
    x.r = r; x.e = e;
    sbq.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; mode = 2'($urandom_range(0, 3));
  endtask

  // Called at the negedge after the accepting edge.
  task automatic wait_result(input string tag);
    int lat = 0;
    exp_t x;
    while (!out_valid && lat < 3 * NCH) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(NCH));
    if (out_valid && sbq.size() > 0) begin
      x = sbq.pop_front();
      chk({tag, "_result"}, 32'(result), 32'(x.r));
      chk({tag, "_eq"}, 32'(eq), 32'(x.e));
      chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    end else if (sbq.size() > 0) begin
      void'(sbq.pop_front());
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_req(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] m, input logic [RW-1:0] r, input logic e);
    drive_req(a, b, m, r, e);
    wait_result(tag);
    release_out(tag);
  endtask

  vec_t vt[15];

  initial begin
    exp_t rx;
    logic [WIDTH-1:0] ra, rb;
    logic [1:0] rm;
    int stale;

    vt[0]  = '{32'hFFFFFFFF, 32'hFFFFFEFF, 2'd0, 6'd8,  1'b0};
    vt[1]  = '{32'hFFFF7EFF, 32'hFFFFFEFF, 2'd0, 6'd15, 1'b0};
    vt[2]  = '{32'h00000101, 32'h00000000, 2'd1, 6'd8,  1'b0};
    vt[3]  = '{32'hF0F0F0F0, 32'h0F0F0F0F, 2'd2, 6'd32, 1'b0};
    vt[4]  = '{32'h00000007, 32'h00000000, 2'd3, 6'd1,  1'b0};
    vt[5]  = '{32'h12345678, 32'h12345678, 2'd0, 6'd32, 1'b1};
    vt[6]  = '{32'h12345678, 32'h12345678, 2'd1, 6'd32, 1'b1};
    vt[7]  = '{32'h12345678, 32'h12345678, 2'd2, 6'd0,  1'b1};
    vt[8]  = '{32'h12345678, 32'h12345678, 2'd3, 6'd0,  1'b1};
    vt[9]  = '{32'h80000000, 32'h00000000, 2'd0, 6'd31, 1'b0};
    vt[10] = '{32'h80000000, 32'h00000000, 2'd1, 6'd31, 1'b0};
    vt[11] = '{32'h00000001, 32'h00000000, 2'd1, 6'd0,  1'b0};
    vt[12] = '{32'hFFFFFFFF, 32'h00000000, 2'd2, 6'd32, 1'b0};
    vt[13] = '{32'hFFFFFFFF, 32'h00000000, 2'd3, 6'd0,  1'b0};
    vt[14] = '{32'h00010003, 32'h00000001, 2'd1, 6'd16, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_eq", 32'(eq), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_req($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].m, vt[i].r, vt[i].e);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1)) : $urandom;
      rm = 2'(i % 4);
      rx = ref_calc(ra, rb, rm);
      run_req($sformatf("rnd%0d", i), ra, rb, rm, rx.r, rx.e);
    end

    // Backpressure: result must hold while out_ready stays low.
    drive_req(32'h00F00000, 32'h00000000, 2'd1, 6'd23, 1'b0);
    wait_result("bp");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_result_stable", 32'(result), 32'd23);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end

    // Request presented on the releasing edge is taken one edge later.
    out_ready = 1'b1;
    A = 32'h00000010; B = 32'h0; mode = 2'd0; in_valid = 1'b1;
    rx.r = 6'd4; rx.e = 1'b0;
    sbq.push_back(rx);
    @(negedge clk);
    chk("handoff_not_taken", 32'(in_ready), 32'd1);
    chk("handoff_result_kept", 32'(result), 32'd23);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("handoff_taken", 32'(in_ready), 32'd0);
    wait_result("handoff");
    release_out("handoff");
    chk("idle_result_kept", 32'(result), 32'd4);

    // Reset during SCAN: outputs clear at once, aborted result never shows.
    drive_req(32'h00000300, 32'h00000000, 2'd0, 6'd8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_eq", 32'(eq), 32'd0);
    void'(sbq.pop_back());
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    for (int c = 0; c < 2 * NCH; c++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_out_valid", 32'(stale), 32'd0);
    run_req("post_rst", 32'h00000000, 32'h40000000, 2'd1, 6'd30, 1'b0);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/diff_scan.md
DIFF_SCAN -- requirements
Module: diff_scan

Interface
REQ-001 Parameter WIDTH, default 32, is the operand width in bits; WIDTH SHALL be at least 2.
REQ-002 Parameter CHUNK, default 8, is the number of bits examined per scan cycle; WIDTH % CHUNK SHALL be 0.
REQ-003 Derived constants: NCH = WIDTH/CHUNK, the number of scan cycles; RW = $clog2(WIDTH)+1, the result width.
REQ-004 clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 A  input  WIDTH  first operand.
REQ-009 B  input  WIDTH  second operand.
REQ-010 mode  input  2  operation select: 0=lowest differing bit, 1=highest differing bit, 2=Hamming distance, 3=XOR parity.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  RW  index, count or parity per mode.
REQ-014 eq  output  1  A == B for the captured request.

Function
REQ-015 FSM states SHALL be IDLE, SCAN and HOLD; in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==HOLD).
REQ-016 On a rising edge with in_valid=1 in IDLE, the block SHALL capture X = A^B and mode, clear the chunk counter and accumulators, and enter SCAN.
REQ-017 In SCAN, each cycle SHALL examine chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1, k = 0..NCH-1 in ascending order) and then increment k.
REQ-018 Mode 0: the first set bit found SHALL be latched, and later chunks SHALL NOT overwrite it.
REQ-019 Mode 1: every set bit found SHALL overwrite the latched index, so the index that remains is the highest.
REQ-020 Mode 2: the popcount of each chunk SHALL be added to an RW-bit count; the maximum value WIDTH SHALL fit without overflow.
REQ-021 Mode 3: result[0] SHALL be the XOR-reduction of X, and result[RW-1:1] SHALL be 0.
REQ-022 Latency SHALL be fixed at NCH cycles regardless of the data; there is no early termination.
REQ-023 After the chunk k=NCH-1 edge, the FSM SHALL enter HOLD with result and eq valid. out_valid therefore rises NCH edges after the accepting edge.
REQ-024 If X==0, eq SHALL be 1 and result SHALL be WIDTH in modes 0/1, 0 in mode 2, and 0 in mode 3; otherwise eq SHALL be 0.
REQ-025 In HOLD, result and eq SHALL remain stable while out_ready=0; when out_ready=1 on an edge, the FSM SHALL return to IDLE.
REQ-026 A request presented while out_valid=1 and out_ready=1 SHALL NOT be accepted that edge; it SHALL be accepted on the next edge, from IDLE.
REQ-027 Changes to A, B or mode after the accepting edge SHALL NOT affect the in-flight result.
REQ-028 result and eq SHALL be registered outputs and SHALL change only on entry to HOLD or on reset.

Reset
REQ-029 rst=0 SHALL asynchronously force state=IDLE, in_ready=1, out_valid=0, result=0, eq=0, and clear X, the counter and the accumulators.
REQ-030 rst asserted during SCAN or HOLD SHALL abort the operation, and no result for the aborted request SHALL ever be presented.
REQ-031 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification (WIDTH=32, CHUNK=8)
REQ-032 Mode 0: A=FFFFFFFF, B=FFFFFEFF -> after 4 cycles out_valid=1, result=8, eq=0.
REQ-033 Mode 0 then mode 1: A=FFFF7EFF, B=FFFFFEFF, A=0000_0101, B=0 -> mode 0 result=15; then mode 1 result=8.
REQ-034 Mode 2: A=F0F0F0F0, B=0F0F0F0F -> result=32; then mode 3 with A=00000007, B=0 -> result=1.
REQ-035 Equal operands A=B=12345678, modes 0/1/2 -> eq=1 with result=32, 32 and 0 respectively.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles -> result stable, in_ready=0 throughout; changing A/B/mode during SCAN leaves the result unchanged.
REQ-037 Reset mid-SCAN at cycle 2 -> outputs clear immediately; the next request completes correctly with no stale out_valid.
